// File: rtl/riscv_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and frame constants.
package riscv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } loader_state_t;

  localparam int LOADER_HDR_BYTES  = 2;
  localparam int LOADER_CSUM_BYTES = 1;

endpackage

// File: rtl/instr_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream and pulses word_valid
// the cycle after the fourth byte, while the completed word is held on `word`.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt   <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_en && (byte_cnt == 2'd3);
      if (byte_en) begin
        word[{byte_cnt, 3'b000} +: 8] <= byte_in;
        byte_cnt                     <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Byte-stream program loader: parses LEN/payload/CSUM frames, writes packed words into
// instruction memory and holds the core until a checksum-verified image is in place.
//
//  state   | meaning
//  IDLE    | waiting for start after reset, no bytes accepted
//  LEN_LO  | expecting low byte of the word count
//  LEN_HI  | expecting high byte of the word count, range check
//  DATA    | accepting payload bytes, one memory write per 4 bytes
//  CSUM    | expecting XOR checksum of the payload
//  DONE    | image valid, core released
//  ERROR   | bad length or checksum, core held
module instr_loader
  import riscv_pkg::*;
#(
  parameter int NUM_INSTR = 64,
  parameter int ADDR_W    = $clog2(NUM_INSTR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int          CNT_W   = ADDR_W + 1;
  localparam logic [15:0] MAX_LEN = 16'(NUM_INSTR);

  loader_state_t    state;
  logic [7:0]       len_lo;
  logic [CNT_W-1:0] words_left;
  logic [7:0]       csum;
  logic [15:0]      len_full;
  logic             xfer;
  logic             start_take;
  logic             word_valid;
  logic [31:0]      word;

  // rx_ready drops during the write cycle so at most one byte is ever in flight
  assign rx_ready = ((state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                     (state == ST_DATA)   || (state == ST_CSUM)) && !word_valid;
  assign xfer       = rx_valid && rx_ready;
  assign start_take = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign len_full   = {rx_byte, len_lo};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_take),
    .byte_en    (xfer && (state == ST_DATA)),
    .byte_in    (rx_byte),
    .word       (word),
    .word_valid (word_valid)
  );

  assign imem_we    = word_valid;
  assign imem_wdata = word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      len_lo     <= 8'd0;
      words_left <= '0;
      imem_addr  <= '0;
      csum       <= 8'd0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else if (start_take) begin
      state      <= ST_LEN_LO;
      len_lo     <= 8'd0;
      words_left <= '0;
      imem_addr  <= '0;
      csum       <= 8'd0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        ST_LEN_LO: if (xfer) begin
          len_lo <= rx_byte;
          state  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (xfer) begin
          if (len_full > MAX_LEN) begin
            state    <= ST_ERROR;
            load_err <= 1'b1;
          end else if (len_full == 16'd0) begin
            state <= ST_CSUM;
          end else begin
            words_left <= len_full[CNT_W-1:0];
            state      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (xfer) csum <= csum ^ rx_byte;
          if (word_valid) begin
            words_left <= words_left - CNT_W'(1);
            // the address stays on the last word so a full-depth load never wraps
            if (words_left == CNT_W'(1)) state <= ST_CSUM;
            else imem_addr <= imem_addr + ADDR_W'(1);
          end
        end
        ST_CSUM: if (xfer) begin
          if (rx_byte == csum) begin
            state     <= ST_DONE;
            load_done <= 1'b1;
            core_hold <= 1'b0;
          end else begin
            state    <= ST_ERROR;
            load_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
